uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side frame controller for the UART RX path. It detects the start bit, times every bit period from `prescale`, and drives one-cycle enable strobes into the start, data (deserializer), parity and stop checkers. It collects the registered checker results and issues `data_valid` or an error pulse per frame. It sits directly upstream of the parity checker, whose `en` input is `par_chk_en` from this block.

## Interface
- `DATA_WIDTH`, 8, number of data bits per frame.
- `clk`  input  1  single clock for the block.
- `rst`  input  1  asynchronous, active-low reset.
- `RX_IN`  input  1  serial line; idle high.
- `PAR_EN`  input  1  parity bit present in the frame; latched at frame start.
- `prescale`  input  6  clocks per bit; any even value 8..32; latched at frame start.
- `strt_glitch`  input  1  registered start-check result; valid at `edge_cnt == SP+1`.
- `par_err`  input  1  registered parity-check result; valid at `edge_cnt == SP+1`.
- `stp_err`  input  1  registered stop-check result; valid at `edge_cnt == SP+1`.
- `edge_cnt`  output  6  clock index within the current bit, 0..prescale-1.
- `bit_cnt`  output  4  bit index within the frame: start = 0, data = 1..DATA_WIDTH, then parity, then stop.
- `dat_samp_en`  output  1  oversampler enable; high in every state except IDLE.
- `strt_chk_en`, `deser_en`, `par_chk_en`, `stp_chk_en`  output  1 each  one-cycle checker/deserializer strobes.
- `data_valid`  output  1  one-cycle pulse when the frame is good.
- `parity_fail`  output  1  one-cycle pulse when the frame has a parity error.
- `frame_err`  output  1  one-cycle pulse when the stop bit is bad.

## Operation
- Sample point: SP = prescale/2 + 2. Sampled bit is valid at `edge_cnt == SP`.
- States are IDLE, START, DATA, PARITY, STOP.
- `edge_cnt` increments every cycle outside IDLE. It wraps to 0 at prescale-1; `bit_cnt` increments on that wrap.
- IDLE: counters are 0. When RX_IN is sampled low: go to START, clear `edge_cnt`, latch PAR_EN and prescale.
- START: pulse `strt_chk_en` at SP. At `edge_cnt == prescale-1`:
  - `strt_glitch` = 1 → IDLE.
  - otherwise → DATA.
- DATA: pulse `deser_en` at SP. At the end of data bit DATA_WIDTH:
  - latched PAR_EN = 1 → PARITY.
  - otherwise → STOP.
- PARITY: pulse `par_chk_en` at SP. Capture `par_err` at SP+1 into internal `par_fail_q`. At end of bit → STOP.
- STOP: pulse `stp_chk_en` at SP. At SP+1 (evaluation cycle), go to IDLE, then:
  - `stp_err` = 1 → `frame_err`.
  - else `par_fail_q` = 1 → `parity_fail`.
  - else → `data_valid`.
  - At most one of the three pulses fires per frame.
- Leaving STOP at SP+1 (mid stop bit) allows a back-to-back start bit to be seen.
- `par_fail_q` clears on entry to START.
- `par_err` is sampled only at PARITY SP+1. Its stale value at any other time is ignored.
- PAR_EN and prescale changes mid-frame have no effect.

## Timing
- Reset state: IDLE. All outputs 0, counters 0, `par_fail_q` 0.
- Reset is asynchronous, takes effect mid-frame, and aborts the frame with no pulse.
- Cycle 0 is the first START cycle (`edge_cnt` = 0).
- The evaluation cycle is (1+DATA_WIDTH+PAR_EN)·prescale + SP + 1.
- Result pulses are registered and appear one cycle after the evaluation cycle, at (1+DATA_WIDTH+PAR_EN)·prescale + SP + 2.
- All strobes are exactly one cycle wide, with exactly one strobe per bit.
- A start glitch returns to IDLE at cycle prescale.

## Test plan
- prescale=8, PAR_EN=1, even parity, byte 0xA5 with parity bit 0, clean stop → `data_valid` high only at cycle 88; `deser_en` pulses 8 times at cycles 14,22,…,70; `par_chk_en` pulses at 78.
- Same frame with parity bit 1 → `parity_fail` at cycle 88; `data_valid` and `frame_err` stay 0.
- prescale=8, RX_IN low for 3 cycles then high → `strt_glitch` seen; IDLE at cycle 8; no `deser_en`; no result pulse.
- prescale=16, PAR_EN=0, 0x3C with stop bit driven 0 → `frame_err` at 9·16+10+2 = 156; no `data_valid`.
- prescale=16, PAR_EN=0, frames 0x01 then 0xFF back-to-back with 1 stop bit → two `data_valid` pulses exactly 160 cycles apart.
- rst asserted at cycle 30 of a prescale=8 frame, released, then a clean 0x5A frame with PAR_EN=0 → outputs 0 during reset; `data_valid` at 9·8+8 = 80 cycles after the new START.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Checker-side bundle of the UART RX frame controller: bit timing, the one-cycle
// checker/deserializer strobes, and the registered results coming back from the checkers.
interface uart_rx_ctrl_if;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       deser_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;

    modport master (
        output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
        input  strt_glitch, par_err, stp_err
    );

    modport slave (
        input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
        output strt_glitch, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: detects the start bit, times each bit from the latched prescale,
// strobes the checkers once per bit at the sample point and reports one result pulse per frame.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic [5:0]            prescale,
    uart_rx_ctrl_if.master        chk,
    output logic                  data_valid,
    output logic                  parity_fail,
    output logic                  frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [5:0] edge_cnt_r;
    logic [5:0] edge_nxt_s;
    logic [3:0] bit_cnt_r;
    logic [3:0] bit_nxt_s;
    logic [5:0] ps_r;
    logic [5:0] ps_nxt_s;
    logic       pen_r;
    logic       pen_nxt_s;
    logic       par_fail_r;
    logic       par_fail_nxt_s;
    logic       dv_nxt_s;
    logic       pf_nxt_s;
    logic       fe_nxt_s;
    logic [5:0] sp_s;
    logic [5:0] sp_nxt_s;
    logic       last_edge_s;
    logic       eval_edge_s;
    logic       at_sp_nxt_s;

    logic       samp_en_r;
    logic       strt_chk_en_r;
    logic       deser_en_r;
    logic       par_chk_en_r;
    logic       stp_chk_en_r;
    logic       data_valid_r;
    logic       parity_fail_r;
    logic       frame_err_r;

    // Sample point and bit-boundary decode for the bit currently being timed
    always_comb begin
        sp_s        = {1'b0, ps_r[5:1]} + 6'd2;
        last_edge_s = (edge_cnt_r == (ps_r - 6'd1));
        eval_edge_s = (edge_cnt_r == (sp_s + 6'd1));
    end

    // Next-state, counter and result decode
    always_comb begin
        state_nxt_s    = state_r;
        edge_nxt_s     = 6'd0;
        bit_nxt_s      = 4'd0;
        ps_nxt_s       = ps_r;
        pen_nxt_s      = pen_r;
        par_fail_nxt_s = par_fail_r;
        dv_nxt_s       = 1'b0;
        pf_nxt_s       = 1'b0;
        fe_nxt_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_nxt_s    = ST_START;
                    ps_nxt_s       = prescale;
                    pen_nxt_s      = PAR_EN;
                    par_fail_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (last_edge_s) begin
                    state_nxt_s = chk.strt_glitch ? ST_IDLE : ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (last_edge_s && (bit_cnt_r == LAST_DATA_BIT)) begin
                    state_nxt_s = pen_r ? ST_PARITY : ST_STOP;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                // par_err is only meaningful the cycle after our own par_chk_en strobe
                if (eval_edge_s) begin
                    par_fail_nxt_s = chk.par_err;
                end else begin
                    par_fail_nxt_s = par_fail_r;
                end
                if (last_edge_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed
                if (eval_edge_s) begin
                    state_nxt_s = ST_IDLE;
                    if (chk.stp_err) begin
                        fe_nxt_s = 1'b1;
                    end else if (par_fail_r) begin
                        pf_nxt_s = 1'b1;
                    end else begin
                        dv_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if ((state_r == ST_IDLE) || (state_nxt_s == ST_IDLE)) begin
            edge_nxt_s = 6'd0;
            bit_nxt_s  = 4'd0;
        end else if (last_edge_s) begin
            edge_nxt_s = 6'd0;
            bit_nxt_s  = bit_cnt_r + 4'd1;
        end else begin
            edge_nxt_s = edge_cnt_r + 6'd1;
            bit_nxt_s  = bit_cnt_r;
        end

        sp_nxt_s    = {1'b0, ps_nxt_s[5:1]} + 6'd2;
        at_sp_nxt_s = (edge_nxt_s == sp_nxt_s);
    end

    // State, counters, latched frame configuration and registered strobes/results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            edge_cnt_r    <= 6'd0;
            bit_cnt_r     <= 4'd0;
            ps_r          <= 6'd8;
            pen_r         <= 1'b0;
            par_fail_r    <= 1'b0;
            samp_en_r     <= 1'b0;
            strt_chk_en_r <= 1'b0;
            deser_en_r    <= 1'b0;
            par_chk_en_r  <= 1'b0;
            stp_chk_en_r  <= 1'b0;
            data_valid_r  <= 1'b0;
            parity_fail_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            edge_cnt_r    <= edge_nxt_s;
            bit_cnt_r     <= bit_nxt_s;
            ps_r          <= ps_nxt_s;
            pen_r         <= pen_nxt_s;
            par_fail_r    <= par_fail_nxt_s;
            samp_en_r     <= (state_nxt_s != ST_IDLE);
            strt_chk_en_r <= at_sp_nxt_s && (state_nxt_s == ST_START);
            deser_en_r    <= at_sp_nxt_s && (state_nxt_s == ST_DATA);
            par_chk_en_r  <= at_sp_nxt_s && (state_nxt_s == ST_PARITY);
            stp_chk_en_r  <= at_sp_nxt_s && (state_nxt_s == ST_STOP);
            data_valid_r  <= dv_nxt_s;
            parity_fail_r <= pf_nxt_s;
            frame_err_r   <= fe_nxt_s;
        end
    end

    assign chk.edge_cnt    = edge_cnt_r;
    assign chk.bit_cnt     = bit_cnt_r;
    assign chk.dat_samp_en = samp_en_r;
    assign chk.strt_chk_en = strt_chk_en_r;
    assign chk.deser_en    = deser_en_r;
    assign chk.par_chk_en  = par_chk_en_r;
    assign chk.stp_chk_en  = stp_chk_en_r;
    assign data_valid      = data_valid_r;
    assign parity_fail     = parity_fail_r;
    assign frame_err       = frame_err_r;

endmodule
